// File: rtl/traceback_unit.sv
`default_nettype none
// traceback_unit -- Viterbi survivor-path traceback; decoded bits buffered and delivered oldest stage first.
// Revision 1.0
module traceback_unit #(
  parameter int NUM_STATE = 4,
  parameter int TB_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          i_en_t,
  input  logic [$clog2(NUM_STATE)-1:0]  i_best_state,
  input  logic [$clog2(TB_DEPTH+1)-1:0] i_td_len,
  output logic                          o_td_rd,
  output logic [$clog2(TB_DEPTH)-1:0]   o_td_addr,
  input  logic [NUM_STATE-1:0]          i_td_data,
  output logic                          o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_busy,
  output logic                          o_done
);

  localparam int M  = $clog2(NUM_STATE);
  localparam int AW = $clog2(TB_DEPTH);
  localparam int LW = $clog2(TB_DEPTH + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [M-1:0]        s_q, s_d;
  logic [AW-1:0]       t_q, t_d;
  logic [AW-1:0]       k_q, k_d;
  logic [LW-1:0]       len_q, len_d;
  logic [TB_DEPTH-1:0] dec_buf_q;

  logic [LW-1:0]       w_len_sat;
  logic                w_dec_bit;
  logic [M-1:0]        w_pred;
  logic                w_last_k;

  always_comb begin
    w_len_sat = (i_td_len > LW'(TB_DEPTH)) ? LW'(TB_DEPTH) : i_td_len;
    w_dec_bit = i_td_data[s_q];
    // Predecessor: shift the decision bit in as the new LSB, dropping the old MSB.
    w_pred    = M'({s_q, w_dec_bit});
    w_last_k  = (k_q == AW'(len_q - LW'(1)));
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    t_d     = t_q;
    k_d     = k_q;
    len_d   = len_q;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (i_en_t) begin
            s_d   = i_best_state;
            len_d = w_len_sat;
            k_d   = '0;
            if (w_len_sat != '0) begin
              t_d     = AW'(w_len_sat - LW'(1));
              state_d = ST_ADDR;
            end else begin
              t_d     = '0;
              state_d = ST_DONE;
            end
          end
        end
        ST_ADDR: state_d = ST_CALC;
        ST_CALC: begin
          s_d = w_pred;
          if (t_q == '0) begin
            k_d     = '0;
            state_d = ST_OUT;
          end else begin
            t_d     = t_q - AW'(1);
            state_d = ST_ADDR;
          end
        end
        ST_OUT: begin
          if (i_ready) begin
            if (w_last_k) state_d = ST_DONE;
            else          k_d     = k_q + AW'(1);
          end
        end
        ST_DONE: begin
          if (!i_en_t) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      t_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      t_q     <= t_d;
      k_q     <= k_d;
      len_q   <= len_d;
    end
  end

  // Decoded-bit buffer carries no reset; OUT only reads entries written by the current block.
  always_ff @(posedge clk) begin
    if (en && (state_q == ST_CALC)) dec_buf_q[t_q] <= s_q[M-1];
  end

  assign o_td_rd   = en && (state_q == ST_ADDR);
  assign o_td_addr = t_q;
  assign o_valid   = (state_q == ST_OUT);
  assign o_data    = o_valid && dec_buf_q[k_q];
  assign o_busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign o_done    = (state_q == ST_DONE);

`ifndef SYNTHESIS
  a_rd_valid_excl: assert property (@(posedge clk) disable iff (rst) !(o_td_rd && o_valid));
`endif

endmodule
`default_nettype wire

// File: tb/tb_traceback_unit.sv
`default_nettype none
// tb_traceback_unit -- bench for traceback_unit with an in-bench trellis traceback model.
// Revision 1.0
module tb_traceback_unit;

  localparam int NS = 4;
  localparam int TD = 8;
  localparam int M  = $clog2(NS);

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     en;
  logic                     i_en_t;
  logic [M-1:0]             i_best_state;
  logic [$clog2(TD+1)-1:0]  i_td_len;
  logic                     o_td_rd;
  logic [$clog2(TD)-1:0]    o_td_addr;
  logic [NS-1:0]            i_td_data;
  logic                     o_data;
  logic                     o_valid;
  logic                     i_ready;
  logic                     o_busy;
  logic                     o_done;

  int errors = 0;
  int checks = 0;

  logic [NS-1:0] surv [TD];
  int            exp_addr [$];
  bit            exp_bits [$];
  int            reads_seen;
  int            bits_seen;

  bit            have_prev;
  bit            p_valid;
  bit            p_xfer;
  bit            p_en;
  bit            p_data;
  logic [6:0]    p_vec;

  always #5 clk = ~clk;

  traceback_unit #(.NUM_STATE(NS), .TB_DEPTH(TD)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .i_en_t       (i_en_t),
    .i_best_state (i_best_state),
    .i_td_len     (i_td_len),
    .o_td_rd      (o_td_rd),
    .o_td_addr    (o_td_addr),
    .i_td_data    (i_td_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  // Survivor memory: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (o_td_rd) i_td_data <= surv[o_td_addr];
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Walk the trellis backwards from the best state: the MSB of the state at
  // stage t is that stage's decoded bit, and the decision bit picks the predecessor.
  function automatic logic [15:0] trace_bits(input int b, input int L);
    logic [15:0] r;
    int s;
    r = '0;
    s = b;
    for (int t = L - 1; t >= 0; t--) begin
      r[t] = (s >> (M - 1)) & 1;
      s = ((s * 2) + int'(surv[t][s])) % NS;
    end
    return r;
  endfunction

  task automatic load_expect(input int b, input int L);
    logic [15:0] bits;
    bits = trace_bits(b, L);
    exp_addr.delete();
    exp_bits.delete();
    for (int t = L - 1; t >= 0; t--) exp_addr.push_back(t);
    for (int k = 0; k < L; k++) exp_bits.push_back(bits[k]);
    reads_seen = 0;
    bits_seen  = 0;
  endtask

  // Per-cycle compare process, sampling mid-cycle.
  initial begin
    have_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_prev = 0;
      end else begin
        chk(!(o_td_rd && o_valid), "rd_valid_exclusive", {o_td_rd, o_valid}, 0);
        if (!en) chk(!o_td_rd, "rd_while_frozen", o_td_rd, 0);
        if (o_td_rd) begin
          if (exp_addr.size() == 0) begin
            chk(1'b0, "extra_read", o_td_addr, -1);
          end else begin
            chk(o_td_addr == exp_addr[0], "read_addr", o_td_addr, exp_addr[0]);
            void'(exp_addr.pop_front());
            reads_seen++;
          end
        end
        if (o_valid) begin
          if (exp_bits.size() == 0) begin
            chk(1'b0, "extra_valid", o_data, -1);
          end else if (i_ready && en) begin
            chk(o_data == exp_bits[0], "out_bit", o_data, exp_bits[0]);
            void'(exp_bits.pop_front());
            bits_seen++;
          end
        end
        if (have_prev && !p_en)
          chk({o_td_addr, o_valid, o_data, o_busy, o_done} == p_vec, "freeze_hold",
              {o_td_addr, o_valid, o_data, o_busy, o_done}, p_vec);
        if (have_prev && p_valid && !p_xfer)
          chk(o_valid && (o_data == p_data), "stall_hold", {o_valid, o_data}, {1'b1, p_data});
        have_prev = 1;
        p_valid   = o_valid;
        p_xfer    = o_valid && i_ready && en;
        p_en      = en;
        p_data    = o_data;
        p_vec     = {o_td_addr, o_valid, o_data, o_busy, o_done};
      end
    end
  end

  // mode 0: en=1/ready=1; 1: ready pattern in OUT; 2: en frozen 3 cycles in ADDR and OUT; 3: random.
  task automatic run_block(input int b, input int len, input int mode, input bit drop, input bit do_rst);
    int L, n, first_v, done_n, p, exp_done;
    bit rst_pending;
    bit pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    L = (len > TD) ? TD : len;
    rst_pending = do_rst;
    load_expect(b, L);
    @(posedge clk); #1;
    i_best_state = M'(b);
    i_td_len     = 4'(len);
    i_en_t       = 1'b1;
    en           = 1'b1;
    i_ready      = 1'b1;
    n = 0; first_v = -1; done_n = -1; p = 0;
    while (done_n < 0 && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (rst_pending && n == 6) begin
        rst = 1'b1;
        #1;
        chk({o_td_rd, o_td_addr, o_data, o_valid, o_busy, o_done} == '0, "async_reset_outputs",
            {o_td_rd, o_td_addr, o_data, o_valid, o_busy, o_done}, 0);
        load_expect(b, L);
        @(negedge clk); #1;
        rst = 1'b0;
        rst_pending = 0;
        n = 0;
        first_v = -1;
        continue;
      end
      if (o_valid && first_v < 0) first_v = n;
      if (o_done) done_n = n;
      if (drop && (o_busy || o_done)) i_en_t = 1'b0;
      case (mode)
        1: begin
          en = 1'b1;
          i_ready = 1'b1;
          if (first_v >= 0 && p < 7) begin
            i_ready = pat[p];
            p++;
          end
        end
        2: begin
          en = !((n >= 1 && n <= 3) || (first_v >= 0 && n < first_v + 3));
          i_ready = 1'b1;
        end
        3: begin
          en      = ($urandom_range(0, 5) != 0);
          i_ready = ($urandom_range(0, 3) != 0);
        end
        default: begin
          en = 1'b1;
          i_ready = 1'b1;
        end
      endcase
    end
    chk(done_n >= 0, "done_timeout", done_n, 0);
    chk(reads_seen == L, "read_count", reads_seen, L);
    chk(bits_seen == L, "bit_count", bits_seen, L);
    if (mode < 3) begin
      exp_done = (L > 0) ? 3 * L + 1 : 1;
      if (mode == 1) exp_done += 3;
      if (mode == 2) exp_done += 6;
      chk(done_n == exp_done, "done_latency", done_n, exp_done);
      if (mode == 0 && L > 0) chk(first_v == 2 * L + 1, "first_valid_latency", first_v, 2 * L + 1);
    end
    en = 1'b1;
    i_ready = 1'b1;
    if (!drop) begin
      repeat (2) @(posedge clk);
      #1;
      chk(o_done && !o_busy, "done_hold", {o_busy, o_done}, 1);
    end
    i_en_t = 1'b0;
    n = 0;
    while (o_done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(!o_done && !o_busy, "done_exit", {o_busy, o_done}, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic load_req034_words();
    for (int t = 0; t < TD; t++) surv[t] = '0;
    surv[2] = 4'b0100;
  endtask

  initial begin
    logic [15:0] r;
    rst = 1'b1; en = 1'b1; i_en_t = 1'b0; i_ready = 1'b1;
    i_best_state = '0; i_td_len = '0;
    for (int t = 0; t < TD; t++) surv[t] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk({o_td_rd, o_td_addr, o_data, o_valid, o_busy, o_done} == '0, "reset_outputs",
        {o_td_rd, o_td_addr, o_data, o_valid, o_busy, o_done}, 0);
    @(negedge clk); #1;
    rst = 1'b0;

    load_req034_words();
    r = trace_bits(3, 4);
    chk(r[3:0] == 4'b1101, "model_pin_req034", r[3:0], 4'b1101);
    surv[1] = 4'b0100;
    surv[2] = 4'b0000;
    r = trace_bits(2, 2);
    chk(r[1:0] == 2'b10, "model_pin_short", r[1:0], 2'b10);

    load_req034_words();
    run_block(3, 4, 0, 0, 0);
    run_block(3, 4, 1, 0, 0);
    run_block(3, 0, 0, 0, 0);
    for (int t = 0; t < TD; t++) surv[t] = 4'($urandom_range(0, 15));
    run_block(int'($urandom_range(0, 3)), 12, 0, 0, 0);
    load_req034_words();
    run_block(3, 4, 0, 0, 1);
    run_block(3, 4, 2, 0, 0);
    run_block(3, 4, 0, 1, 0);

    for (int i = 0; i < 30; i++) begin
      for (int t = 0; t < TD; t++) surv[t] = 4'($urandom_range(0, 15));
      run_block(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 3,
                ($urandom_range(0, 2) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traceback_unit.md
TRACEBACK_UNIT -- requirements
Module: traceback_unit

Interface
REQ-001 SHALL have parameter NUM_STATE, default 4, meaning trellis state count (2^M, M = K-1 = 2).
REQ-002 SHALL have parameter TB_DEPTH, default 8, meaning maximum trellis stages stored and traced per block.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports are named clk and rst.
REQ-004 SHALL have port clk, input, 1, rising-edge system clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1, global enable; when 0, all registers hold.
REQ-007 SHALL have port i_en_t, input, 1, traceback enable from the control FSM; held high while traceback is permitted.
REQ-008 SHALL have port i_best_state, input, log2(NUM_STATE), start state for traceback; sampled at start.
REQ-009 SHALL have port i_td_len, input, log2(TB_DEPTH+1), number of valid stages in survivor memory; sampled at start.
REQ-010 SHALL have port o_td_rd, output, 1, survivor-memory read strobe.
REQ-011 SHALL have port o_td_addr, output, log2(TB_DEPTH), survivor-memory stage address.
REQ-012 SHALL have port i_td_data, input, NUM_STATE, survivor decision word; bit s = decision bit for state s; valid one cycle after o_td_rd.
REQ-013 SHALL have port o_data, output, 1, decoded bit.
REQ-014 SHALL have port o_valid, output, 1, o_data valid.
REQ-015 SHALL have port i_ready, input, 1, downstream accepts o_data.
REQ-016 SHALL have port o_busy, output, 1, high in any state except IDLE and DONE.
REQ-017 SHALL have port o_done, output, 1, block fully delivered; high only in DONE.

Function
REQ-018 SHALL implement FSM states IDLE, ADDR, CALC, OUT, DONE.
REQ-019 IDLE: when en=1 and i_en_t=1, latch state reg S=i_best_state, L=i_td_len, stage counter t=L-1; go ADDR if L>0, else DONE.
REQ-020 ADDR: drive o_td_rd=1, o_td_addr=t for one cycle; go CALC.
REQ-021 CALC: with d=i_td_data[S], write buf[t]=S[M-1] (state MSB is decoded bit); S<=predecessor={S[M-2:0],d}; if t=0 go OUT with output index k=0, else t<=t-1 and go ADDR.
REQ-022 Trace phase SHALL take exactly 2*L cycles from leaving IDLE to entering OUT.
REQ-023 OUT: o_valid=1, o_data=buf[k]; on a cycle with o_valid&i_ready&en, k<=k+1; after transferring k=L-1, go DONE.
REQ-024 o_valid and o_data SHALL stay stable while i_ready=0 (no drop, no reorder).
REQ-025 Bits SHALL be delivered in forward time order: stage 0 first, stage L-1 last.
REQ-026 DONE: o_done=1; hold until i_en_t=0 sampled with en=1, then go IDLE.
REQ-027 i_en_t falling during ADDR/CALC/OUT SHALL NOT abort the block; the block completes, then DONE exits immediately.
REQ-028 en=0 SHALL freeze state, counters, buffer and outputs; o_td_rd SHALL be forced 0 while en=0, and ADDR SHALL re-issue its read when en returns.
REQ-029 i_td_len > TB_DEPTH SHALL be saturated to TB_DEPTH at latch time.
REQ-030 o_td_rd and o_valid SHALL never be high in the same cycle.

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE, S=0, t=0, k=0, L=0, o_td_rd=0, o_td_addr=0, o_data=0, o_valid=0, o_busy=0, o_done=0.
REQ-032 rst asserted mid-block SHALL discard the block; after release, no stale bits are emitted and a new start is required.
REQ-033 buf contents need not be reset.

Verification
REQ-034 K=3, L=4, best=2'b11, stage words: t0=4'b0000, t1=4'b0000, t2=4'b0100, t3=4'b0000, i_ready=1 -> reads at addr 3,2,1,0; o_data 1,0,1,1 on four consecutive cycles starting 8 cycles after start; then o_done=1.
REQ-035 Same block, i_ready toggled 1,0,0,1,0,1,1 -> each bit held while i_ready=0; sequence still 1,0,1,1; no duplicates.
REQ-036 i_td_len=0 -> no o_td_rd, no o_valid; o_done=1 the cycle after start.
REQ-037 i_td_len=12 with TB_DEPTH=8 -> exactly 8 reads (addr 7..0) and 8 output bits.
REQ-038 rst pulsed during the CALC for t=1 -> all outputs 0 immediately; after release with i_en_t=1, a full new block is traced from addr L-1.
REQ-039 en=0 for 3 cycles during ADDR and during OUT -> no state change, o_td_rd=0 while frozen; final sequence identical to REQ-034.
